// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl operation codes, execution-unit FSM state
// encoding and a small classifier used by both the control decoder and the
// execution unit.
package alu_pkg;

  // ALUCtrl operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  // Execution-unit FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    KIND_COMB  = 2'd0,
    KIND_SHIFT = 2'd1,
    KIND_UNDEF = 2'd2
  } alu_kind_e;

  // Classify an operation code: single-cycle, multi-cycle shift, or undefined.
  function automatic alu_kind_e alu_kind(input logic [3:0] code);
    alu_kind_e k;
    case (code)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: k = KIND_COMB;
      ALU_SLL, ALU_SRL, ALU_SRA:                  k = KIND_SHIFT;
      default:                                    k = KIND_UNDEF;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: add, sub, and, or, signed set-less-than.
// Shift codes produce zero here (the parent sequences them); undefined codes
// produce zero and raise o_illegal.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_ctrl,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal
);

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic                    w_lt;

  assign w_a_s = i_op_a;
  assign w_b_s = i_op_b;
  assign w_lt  = (w_a_s < w_b_s);

  // Operation select; add/sub wrap modulo 2^WIDTH by construction.
  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_ctrl)
      ALU_ADD: o_result = i_op_a + i_op_b;
      ALU_SUB: o_result = i_op_a - i_op_b;
      ALU_AND: o_result = i_op_a & i_op_b;
      ALU_OR:  o_result = i_op_a | i_op_b;
      ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SLL, ALU_SRL, ALU_SRA: o_result = '0;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshake on both sides.
// Single-cycle ops complete on the accepting edge; shifts move the working
// register one bit per clock, the first bit being shifted on the accepting
// edge, so a k-bit shift presents its result k cycles after the request.
// The result register doubles as the shift working register.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [SHW-1:0]   r_cnt;
  logic             r_illegal;

  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_comb_result;
  logic             w_comb_illegal;

  // One-bit step of a shift, fill chosen by the operation.
  function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] code,
                                                 input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] s;
    case (code)
      ALU_SLL: s = {v[WIDTH-2:0], 1'b0};
      ALU_SRL: s = {1'b0, v[WIDTH-1:1]};
      default: s = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
    return s;
  endfunction

  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_shamt   = op_b[SHW-1:0];
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign illegal   = r_illegal;
  assign zero      = (r_result == '0);

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .i_ctrl    (ALUCtrl),
    .i_op_a    (op_a),
    .i_op_b    (op_b),
    .o_result  (w_comb_result),
    .o_illegal (w_comb_illegal)
  );

  // Handshake FSM, shift sequencing and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= ALUCtrl;
            if (alu_kind(ALUCtrl) == KIND_SHIFT) begin
              r_illegal <= 1'b0;
              if (w_shamt == '0) begin
                r_result <= op_a;
                r_state  <= ST_DONE;
              end else begin
                r_result <= shift_one(ALUCtrl, op_a);
                r_cnt    <= w_shamt - SHW'(1);
                r_state  <= (w_shamt == SHW'(1)) ? ST_DONE : ST_SHIFT;
              end
            end else begin
              r_result  <= w_comb_result;
              r_illegal <= w_comb_illegal;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          r_result <= shift_one(r_op, r_result);
          r_cnt    <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit (WIDTH=32) with a behavioural
// reference model and a per-cycle output monitor.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALUCtrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int checks = 0;
  int errors = 0;

  // Expected transaction currently owed by the DUT
  logic         exp_active = 1'b0;
  logic [W-1:0] exp_res    = '0;
  logic         exp_ill    = 1'b0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUCtrl   (ALUCtrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: what the result must be, from plain arithmetic.
  function automatic logic [W-1:0] model_res(input logic [3:0] c,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    int k;
    k = int'(b[4:0]);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return a << k;
      4'b1001: return a >> k;
      4'b1010: return W'($signed(a) >>> k);
      default: return '0;
    endcase
  endfunction

  function automatic logic model_ill(input logic [3:0] c);
    return !(c inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                       4'b1000, 4'b1001, 4'b1010});
  endfunction

  // Cycles from request cycle to the first cycle with out_valid high.
  function automatic int model_lat(input logic [3:0] c, input logic [W-1:0] b);
    int k;
    k = int'(b[4:0]);
    if (c inside {4'b1000, 4'b1001, 4'b1010} && k > 0) return k;
    return 1;
  endfunction

  // Output monitor: whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_active) begin
        chk("stray_out_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("mon_result",  64'(result),  64'(exp_res));
        chk("mon_zero",    64'(zero),    64'(exp_res == '0));
        chk("mon_illegal", 64'(illegal), 64'(exp_ill));
      end
    end
  end

  // Issue one request, check latency and the hand-computed result, optionally
  // stall the consumer for 'hold' cycles while offering junk requests.
  task automatic run_op(input string nm, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] lit, input int hold);
    int lat;
    logic [W-1:0] held;
    lat = model_lat(c, b);
    @(negedge clk);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; ALUCtrl = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    exp_res    = model_res(c, a, b);
    exp_ill    = model_ill(c);
    exp_active = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i < lat) begin
        chk({nm, "_busy_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_busy_ready"}, 64'(in_ready),  64'd0);
      end else begin
        chk({nm, "_valid"},  64'(out_valid), 64'd1);
        chk({nm, "_ready0"}, 64'(in_ready),  64'd0);
        chk({nm, "_lit"},    64'(result),    64'(lit));
      end
    end
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; ALUCtrl = 4'b0010; op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      chk({nm, "_hold_valid"},  64'(out_valid), 64'd1);
      chk({nm, "_hold_result"}, 64'(result),    64'(held));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_active = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    chk({nm, "_rel_ready"}, 64'(in_ready),  64'd1);
    chk({nm, "_rel_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUCtrl = '0; op_a = '0; op_b = '0;
    #3;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    64'(result),    64'd0);
    chk("rst_zero",      64'(zero),      64'd1);
    chk("rst_illegal",   64'(illegal),   64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op("add",      4'b0010, 32'd5, 32'd7, 32'd12, 0);
    run_op("sub_eq",   4'b0110, 32'd3, 32'd3, 32'd0, 0);
    run_op("sub_wrap", 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd1, 0);
    run_op("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0);
    run_op("or",       4'b0001, 32'hF000_0001, 32'h000F_0010, 32'hF00F_0011, 0);
    run_op("sra4",     4'b1010, 32'h8000_0000, 32'd4, 32'hF800_0000, 0);
    run_op("sra0",     4'b1010, 32'h8000_0000, 32'd32, 32'h8000_0000, 0);
    run_op("sra1",     4'b1010, 32'h8000_0002, 32'd1, 32'hC000_0001, 0);
    run_op("sll3",     4'b1000, 32'hA000_0001, 32'd3, 32'h0000_0008, 0);
    run_op("srl31",    4'b1001, 32'h8000_0000, 32'd31, 32'h0000_0001, 0);
    run_op("sra_pos",  4'b1010, 32'h4000_0000, 32'd30, 32'h0000_0001, 0);
    run_op("hold",     4'b0001, 32'h0000_00A0, 32'h0000_000B, 32'h0000_00AB, 5);
    run_op("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    run_op("slt_pos",  4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("slt_eq",   4'b0111, 32'd9, 32'd9, 32'd0, 0);
    run_op("undef_f",  4'b1111, 32'd5, 32'd6, 32'd0, 0);
    chk("undef_f_illegal", 64'(illegal), 64'd1);
    chk("undef_f_zero",    64'(zero),    64'd1);
    run_op("undef_3",  4'b0011, 32'd5, 32'd6, 32'd0, 0);
    run_op("def_after_undef", 4'b0010, 32'd1, 32'd1, 32'd2, 0);
    chk("def_illegal_clear", 64'(illegal), 64'd0);

    // Reset in the middle of a long shift: nothing may be produced.
    @(negedge clk);
    in_valid = 1'b1; ALUCtrl = 4'b1001; op_a = 32'hFFFF_0000; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_shift_busy", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid",  64'(out_valid), 64'd0);
    chk("mrst_ready",  64'(in_ready),  64'd1);
    chk("mrst_result", 64'(result),    64'd0);
    chk("mrst_zero",   64'(zero),      64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 64'(out_valid), 64'd0);
    end
    run_op("post_rst_add", 4'b0010, 32'd100, 32'd23, 32'd123, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
